// File: rtl/fetch_unit_param.sv
// rtl/fetch_unit_param.sv - parametrised PC and instruction fetch stage, one request in flight
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
module fetch_unit_param #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     IMEM_AW      = 8,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_en,
  output logic               m_req,
  output logic [IMEM_AW-1:0] m_addr,
  input  logic               m_valid,
  input  logic [31:0]        m_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [31:0]        inst_data,
  output logic [XLEN-1:0]    inst_pc,
  output logic [XLEN-1:0]    pc_q,
  output logic               fetch_err
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t          state_q, state_d;
  state_t          resume_state;
  logic [XLEN-1:0] pc_d;
  logic            kill_q, kill_d;
  logic            m_req_q, m_req_d;
  logic            inst_valid_q, inst_valid_d;
  logic [31:0]     inst_data_q, inst_data_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            redir;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic err_q, err_d;
  // Once trapped, redirects no longer move the PC.
  assign redir     = redirect_valid && (state_q != S_ERR);
  assign fetch_err = err_q;
`else
  assign redir     = redirect_valid;
  assign fetch_err = 1'b0;
`endif

  assign resume_state = pc_en ? S_REQ : S_IDLE;

  assign m_req      = m_req_q;
  assign m_addr     = pc_q[IMEM_AW+1:2];
  assign inst_valid = inst_valid_q;
  assign inst_data  = inst_data_q;
  assign inst_pc    = inst_pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    err_d        = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pc_en) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT;
        if (redir) kill_d = 1'b1;
      end
      S_WAIT: begin
        if (m_valid) begin
          if (!kill_q && !redir) begin
            inst_valid_d = 1'b1;
            inst_data_d  = m_data;
            inst_pc_d    = pc_q;
            pc_d         = pc_q + PC_STEP;
            state_d      = S_HOLD;
          end else begin
            // Stale response: swallow it and restart from the redirected PC.
            kill_d  = 1'b0;
            state_d = resume_state;
          end
        end else if (redir) begin
          kill_d = 1'b1;
        end
      end
      S_HOLD: begin
        // A redirect alongside ready still completes the transfer.
        if (inst_ready || redir) begin
          inst_valid_d = 1'b0;
          state_d      = resume_state;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      S_ERR: begin
        state_d = S_ERR;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (redir) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      pc_d = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d      = S_ERR;
        err_d        = 1'b1;
        inst_valid_d = 1'b0;
        kill_d       = 1'b0;
      end
`else
      pc_d = redirect_pc & ALIGN_MASK;
`endif
    end

    m_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_VECTOR;
      kill_q       <= 1'b0;
      m_req_q      <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      m_req_q      <= m_req_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      err_q        <= err_d;
`endif
    end
  end

endmodule
